// File: rtl/can_fd_pkg.sv
// Shared types and constants for the CAN FD data-field sequencer.
// FD support in the sequencer is enabled by defining the CAN_FD_EN macro.
package can_fd_pkg;

    localparam int CAN_FD_MAX_BYTES = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        CRC15 = 2'd0,
        CRC17 = 2'd1,
        CRC21 = 2'd2
    } crc_sel_e;

    // FD frames switch from CRC17 to CRC21 above 16 payload bytes.
    function automatic crc_sel_e crc_select(input logic fdf, input logic [6:0] len_bytes);
        crc_sel_e sel;
        if (!fdf) begin
            sel = CRC15;
        end else if (len_bytes > 7'd16) begin
            sel = CRC21;
        end else begin
            sel = CRC17;
        end
        return sel;
    endfunction

endpackage

// File: rtl/can_dlc_decoder.sv
// Maps a raw 4-bit DLC and FDF flag to the payload length in bytes.
// Classic frames saturate at 8 bytes; FD frames use the extended table.
module can_dlc_decoder (
    input  logic [3:0] dlc_i,
    input  logic       fdf_i,
    output logic [6:0] len_bytes_o
);

    // Combinational DLC lookup.
    always_comb begin
        len_bytes_o = 7'd8;
        if (dlc_i <= 4'd8) begin
            len_bytes_o = {3'd0, dlc_i};
        end else if (fdf_i) begin
            case (dlc_i)
                4'd9:    len_bytes_o = 7'd12;
                4'd10:   len_bytes_o = 7'd16;
                4'd11:   len_bytes_o = 7'd20;
                4'd12:   len_bytes_o = 7'd24;
                4'd13:   len_bytes_o = 7'd32;
                4'd14:   len_bytes_o = 7'd48;
                4'd15:   len_bytes_o = 7'd64;
                default: len_bytes_o = 7'd8;
            endcase
        end else begin
            len_bytes_o = 7'd8;
        end
    end

endmodule

// File: rtl/can_fd_data_sequencer.sv
// Assembles destuffed data-field bits into bytes and strobes them out by index.
// Define CAN_FD_EN to honour fd_frame; otherwise every frame is treated as classic.
module can_fd_data_sequencer
    import can_fd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_data,
    input  logic [3:0] data_len,
    input  logic       fd_frame,
    input  logic       sample_point,
    input  logic       bit_valid,
    input  logic       rx_bit,
    input  logic       abort,
    output logic [7:0] byte_out,
    output logic [5:0] byte_addr,
    output logic       byte_we,
    output logic [6:0] data_len_bytes,
    output logic [1:0] crc_sel,
    output logic       busy,
    output logic       data_done
);

    seq_state_e state_q;
    logic [3:0] dlc_q;
    logic       fdf_q;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] byte_out_q;
    logic [5:0] byte_addr_q;
    logic       byte_we_q;
    logic [6:0] data_len_bytes_q;
    crc_sel_e   crc_sel_q;
    logic       busy_q;
    logic       data_done_q;

    logic       fd_eff_s;
    logic [6:0] dec_len_s;
    logic       last_wr_s;

`ifdef CAN_FD_EN
    assign fd_eff_s = fd_frame;
`else
    assign fd_eff_s = fd_frame & 1'b0;
`endif

    can_dlc_decoder u_dlc_decoder (
        .dlc_i       (dlc_q),
        .fdf_i       (fdf_q),
        .len_bytes_o (dec_len_s)
    );

    // The strobe for the final index ends the data field.
    assign last_wr_s = byte_we_q && ({1'b0, byte_addr_q} == (data_len_bytes_q - 7'd1));

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            dlc_q            <= 4'd0;
            fdf_q            <= 1'b0;
            shift_q          <= 8'd0;
            bit_cnt_q        <= 3'd0;
            byte_out_q       <= 8'd0;
            byte_addr_q      <= 6'd0;
            byte_we_q        <= 1'b0;
            data_len_bytes_q <= 7'd0;
            crc_sel_q        <= CRC15;
            busy_q           <= 1'b0;
            data_done_q      <= 1'b0;
        end else if (abort) begin
            state_q     <= ST_IDLE;
            shift_q     <= 8'd0;
            bit_cnt_q   <= 3'd0;
            byte_we_q   <= 1'b0;
            busy_q      <= 1'b0;
            data_done_q <= 1'b0;
        end else begin
            byte_we_q   <= 1'b0;
            data_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_data) begin
                        dlc_q   <= data_len;
                        fdf_q   <= fd_eff_s;
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    data_len_bytes_q <= dec_len_s;
                    crc_sel_q        <= crc_select(fdf_q, dec_len_s);
                    bit_cnt_q        <= 3'd0;
                    byte_addr_q      <= 6'd0;
                    shift_q          <= 8'd0;
                    if (dec_len_s == 7'd0) begin
                        state_q     <= ST_DONE;
                        data_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (last_wr_s) begin
                        state_q     <= ST_DONE;
                        data_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        if (byte_we_q) begin
                            byte_addr_q <= byte_addr_q + 6'd1;
                        end
                        if (sample_point && bit_valid) begin
                            shift_q   <= {shift_q[6:0], rx_bit};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_out_q <= {shift_q[6:0], rx_bit};
                                byte_we_q  <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_out       = byte_out_q;
    assign byte_addr      = byte_addr_q;
    assign byte_we        = byte_we_q;
    assign data_len_bytes = data_len_bytes_q;
    assign crc_sel        = crc_sel_q;
    assign busy           = busy_q;
    assign data_done      = data_done_q;

endmodule

// File: tb/tb_can_fd_data_sequencer.sv
// Directed testbench for can_fd_data_sequencer; expectations follow CAN_FD_EN.
module tb_can_fd_data_sequencer;

`ifdef CAN_FD_EN
    localparam int       EXP_F = 64;
    localparam int       EXP_A = 16;
    localparam int       EXP_D = 32;
    localparam bit [1:0] CRC_F = 2'd2;
    localparam bit [1:0] CRC_A = 2'd1;
    localparam bit [1:0] CRC_D = 2'd2;
    localparam bit [1:0] CRC_Z = 2'd1;
`else
    localparam int       EXP_F = 8;
    localparam int       EXP_A = 8;
    localparam int       EXP_D = 8;
    localparam bit [1:0] CRC_F = 2'd0;
    localparam bit [1:0] CRC_A = 2'd0;
    localparam bit [1:0] CRC_D = 2'd0;
    localparam bit [1:0] CRC_Z = 2'd0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_data = 1'b0;
    logic [3:0] data_len = 4'd0;
    logic       fd_frame = 1'b0;
    logic       sample_point = 1'b0;
    logic       bit_valid = 1'b0;
    logic       rx_bit = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] byte_out;
    logic [5:0] byte_addr;
    logic       byte_we;
    logic [6:0] data_len_bytes;
    logic [1:0] crc_sel;
    logic       busy;
    logic       data_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int last_we_cyc = 0;
    int last_done_cyc = 0;
    int start_cyc = 0;
    logic [7:0] wr_data [256];
    logic [5:0] wr_addr [256];

    can_fd_data_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start_data     (start_data),
        .data_len       (data_len),
        .fd_frame       (fd_frame),
        .sample_point   (sample_point),
        .bit_valid      (bit_valid),
        .rx_bit         (rx_bit),
        .abort          (abort),
        .byte_out       (byte_out),
        .byte_addr      (byte_addr),
        .byte_we        (byte_we),
        .data_len_bytes (data_len_bytes),
        .crc_sel        (crc_sel),
        .busy           (busy),
        .data_done      (data_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write and completion recorder, sampled on the inactive edge.
    always @(negedge clk) begin
        if (byte_we) begin
            if (wr_cnt < 256) begin
                wr_data[wr_cnt] = byte_out;
                wr_addr[wr_cnt] = byte_addr;
            end
            wr_cnt = wr_cnt + 1;
            last_we_cyc = cyc;
        end
        if (data_done) begin
            done_cnt = done_cnt + 1;
            last_done_cyc = cyc;
        end
    end

    task automatic start_frame(input logic [3:0] dlc, input logic fd);
        @(negedge clk);
        start_data = 1'b1;
        data_len   = dlc;
        fd_frame   = fd;
        start_cyc  = cyc;
        @(negedge clk);
        start_data = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic v);
        @(negedge clk);
        sample_point = 1'b1;
        bit_valid    = v;
        rx_bit       = b;
        @(negedge clk);
        sample_point = 1'b0;
        bit_valid    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b1);
    endtask

    task automatic wait_done(input int base, input string name);
        int n;
        n = 0;
        while (done_cnt == base && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done_cnt == base) begin
            bad++;
            $display("FAIL %s timeout: data_done never seen", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({byte_out, byte_addr, byte_we, data_len_bytes, crc_sel, busy, data_done} !== 26'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%0h want=0",
                     {byte_out, byte_addr, byte_we, data_len_bytes, crc_sel, busy, data_done});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy got=%0b want=0", busy); end
    endtask

    task automatic test_classic3();
        int wb, db;
        logic [7:0] exp [3];
        exp[0] = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'hFF;
        wb = wr_cnt; db = done_cnt;
        start_frame(4'd3, 1'b0);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL classic_busy_load got=%0b want=1", busy); end
        for (int k = 0; k < 3; k++) send_byte(exp[k]);
        wait_done(db, "classic_done");
        total++;
        if (wr_cnt - wb != 3) begin bad++; $display("FAIL classic_count got=%0d want=3", wr_cnt - wb); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (wr_data[wb+k] !== exp[k] || wr_addr[wb+k] !== 6'(k)) begin
                bad++;
                $display("FAIL classic_byte%0d got=%0h@%0d want=%0h@%0d", k, wr_data[wb+k], wr_addr[wb+k], exp[k], k);
            end
        end
        total++;
        if (last_done_cyc != last_we_cyc + 1) begin
            bad++; $display("FAIL classic_done_timing got=%0d want=%0d", last_done_cyc, last_we_cyc + 1);
        end
        total++;
        if (crc_sel !== 2'd0 || data_len_bytes !== 7'd3) begin
            bad++; $display("FAIL classic_crc_len got=%0d/%0d want=0/3", crc_sel, data_len_bytes);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || data_done !== 1'b0) begin
            bad++; $display("FAIL classic_idle got busy=%0b done=%0b want 0/0", busy, data_done);
        end
    endtask

    task automatic test_fd64();
        int wb, db, errs;
        logic [7:0] p;
        wb = wr_cnt; db = done_cnt; errs = 0;
        start_frame(4'hF, 1'b1);
        for (int k = 0; k < EXP_F; k++) begin
            p = 8'(k * 37 + 11);
            send_byte(p);
        end
        wait_done(db, "fd64_done");
        send_byte(8'h55);
        send_byte(8'hAA);
        repeat (2) @(negedge clk);
        total++;
        if (wr_cnt - wb != EXP_F) begin bad++; $display("FAIL fd64_count got=%0d want=%0d", wr_cnt - wb, EXP_F); end
        for (int k = 0; k < EXP_F; k++) begin
            p = 8'(k * 37 + 11);
            if (wr_data[wb+k] !== p || wr_addr[wb+k] !== 6'(k)) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL fd64_data got=%0d bad bytes want=0", errs); end
        total++;
        if (data_len_bytes !== 7'(EXP_F) || crc_sel !== CRC_F) begin
            bad++; $display("FAIL fd64_len_crc got=%0d/%0d want=%0d/%0d", data_len_bytes, crc_sel, EXP_F, CRC_F);
        end
        total++;
        if (byte_addr !== 6'(EXP_F - 1)) begin
            bad++; $display("FAIL fd64_addr_hold got=%0d want=%0d", byte_addr, EXP_F - 1);
        end
    endtask

    task automatic test_stuffed();
        int wb, db, errs;
        logic [7:0] p;
        wb = wr_cnt; db = done_cnt; errs = 0;
        start_frame(4'hA, 1'b1);
        for (int k = 0; k < EXP_A; k++) begin
            p = 8'(k * 29 + 3);
            for (int i = 7; i >= 0; i--) begin
                send_bit(p[i], 1'b1);
                if (i % 3 == 1) send_bit(~p[i], 1'b0);
            end
        end
        wait_done(db, "stuff_done");
        total++;
        if (wr_cnt - wb != EXP_A) begin bad++; $display("FAIL stuff_count got=%0d want=%0d", wr_cnt - wb, EXP_A); end
        for (int k = 0; k < EXP_A; k++) begin
            p = 8'(k * 29 + 3);
            if (wr_data[wb+k] !== p || wr_addr[wb+k] !== 6'(k)) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL stuff_data got=%0d bad bytes want=0", errs); end
        total++;
        if (crc_sel !== CRC_A) begin bad++; $display("FAIL stuff_crc got=%0d want=%0d", crc_sel, CRC_A); end
    endtask

    task automatic test_zero_len(input logic fd);
        int wb, db;
        wb = wr_cnt; db = done_cnt;
        start_frame(4'd0, fd);
        wait_done(db, "zero_done");
        total++;
        if (last_done_cyc != start_cyc + 2) begin
            bad++; $display("FAIL zero_timing fd=%0b got=%0d want=%0d", fd, last_done_cyc - start_cyc, 2);
        end
        total++;
        if (wr_cnt != wb || data_len_bytes !== 7'd0) begin
            bad++; $display("FAIL zero_nowrite fd=%0b got=%0d writes len=%0d want 0/0", fd, wr_cnt - wb, data_len_bytes);
        end
        total++;
        if (crc_sel !== (fd ? CRC_Z : 2'd0)) begin
            bad++; $display("FAIL zero_crc fd=%0b got=%0d want=%0d", fd, crc_sel, fd ? CRC_Z : 2'd0);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int wb, db;
        logic [7:0] p;
        wb = wr_cnt; db = done_cnt;
        p = 8'h5A;
        start_frame(4'd5, 1'b0);
        send_byte(p);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
        repeat (4) @(negedge clk);
        total++;
        if (wr_cnt - wb != 1 || wr_data[wb] !== p) begin
            bad++; $display("FAIL abort_writes got=%0d (%0h) want=1 (5a)", wr_cnt - wb, wr_data[wb]);
        end
        total++;
        if (done_cnt != db) begin bad++; $display("FAIL abort_nodone got=%0d want=0", done_cnt - db); end
    endtask

    task automatic test_start_ignored();
        int wb, db;
        wb = wr_cnt; db = done_cnt;
        start_frame(4'd2, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        start_frame(4'd8, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
        send_byte(8'h81);
        wait_done(db, "ignore_done");
        total++;
        if (wr_cnt - wb != 2 || wr_data[wb] !== 8'hF0 || wr_data[wb+1] !== 8'h81 || data_len_bytes !== 7'd2) begin
            bad++; $display("FAIL ignore_start got=%0d writes %0h %0h len=%0d want=2 f0 81 2",
                            wr_cnt - wb, wr_data[wb], wr_data[wb+1], data_len_bytes);
        end
    endtask

    task automatic test_cap();
        int wb, db;
        wb = wr_cnt; db = done_cnt;
        start_frame(4'hD, 1'b1);
        for (int k = 0; k < EXP_D; k++) send_byte(8'(k + 8'h40));
        wait_done(db, "cap_done");
        total++;
        if (wr_cnt - wb != EXP_D || crc_sel !== CRC_D || wr_data[wb+EXP_D-1] !== 8'(EXP_D - 1 + 8'h40)) begin
            bad++; $display("FAIL cap_len got=%0d crc=%0d want=%0d crc=%0d", wr_cnt - wb, crc_sel, EXP_D, CRC_D);
        end
    endtask

    task automatic test_reset_mid();
        int wb;
        wb = wr_cnt;
        start_frame(4'd4, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || byte_addr !== 6'd0 || data_len_bytes !== 7'd0 || byte_out !== 8'd0) begin
            bad++; $display("FAIL rst_mid got busy=%0b addr=%0d len=%0d want 0/0/0", busy, byte_addr, data_len_bytes);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (wr_cnt != wb) begin bad++; $display("FAIL rst_mid_nowrite got=%0d want=0", wr_cnt - wb); end
    endtask

    initial begin
        test_reset();
        test_classic3();
        test_fd64();
        test_stuffed();
        test_zero_len(1'b0);
        test_zero_len(1'b1);
        test_abort();
        test_start_ignored();
        test_cap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
